// File: rtl/bcd_down_counter_n.sv
// Multi-digit BCD countdown timer with built-in tick prescaler, synchronous
// load, pause, and one-shot or auto-reload operation.
module bcd_down_counter_n #(
  parameter int DIGITS = 2,
  parameter int DIV    = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  auto_reload,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  zero,
  output logic                  done,
  output logic                  running
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  ZERO_VAL = '0;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    count_r, count_s;
  logic [PW-1:0]   presc_r, presc_s;
  logic            tick_r, tick_s;
  logic            done_r, done_s;
  logic [W-1:0]    load_clean_s;
  logic [W-1:0]    count_dec_s;

  // Digits above 9 are forced to 9 so only legal BCD ever enters the counter.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  assign load_clean_s = clamp_bcd(load_value);
  assign count_dec_s  = dec_bcd(count_r);

  // Next-state logic: load has priority; otherwise prescale and count while running.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    presc_s = presc_r;
    tick_s  = 1'b0;
    done_s  = 1'b0;
    if (load) begin
      count_s = load_clean_s;
      presc_s = '0;
      state_s = (load_clean_s != ZERO_VAL) ? RUN : IDLE;
    end else if ((state_r == RUN) && en) begin
      if (presc_r == PRESC_MAX) begin
        presc_s = '0;
        tick_s  = 1'b1;
      end else begin
        presc_s = presc_r + PRESC_ONE;
      end
      if (!tick_r) begin
        count_s = count_r;
      end else if (count_r != ZERO_VAL) begin
        // Reaching zero signals done; auto_reload decides whether we keep running.
        count_s = count_dec_s;
        if (count_dec_s == ZERO_VAL) begin
          done_s  = 1'b1;
          state_s = auto_reload ? RUN : IDLE;
        end else begin
          state_s = RUN;
        end
      end else begin
        count_s = load_clean_s;
        if (load_clean_s == ZERO_VAL) begin
          done_s  = 1'b1;
          state_s = auto_reload ? RUN : IDLE;
        end else begin
          state_s = RUN;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, count, prescaler and output pulse registers.
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_r <= IDLE;
      count_r <= '0;
      presc_r <= '0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      presc_r <= presc_s;
      tick_r  <= tick_s;
      done_r  <= done_s;
    end
  end

  assign count   = count_r;
  assign tick    = tick_r;
  assign done    = done_r;
  assign zero    = (count_r == ZERO_VAL);
  assign running = (state_r == RUN);

endmodule

// File: tb/tb_bcd_down_counter_n.sv
// Randomised self-checking bench for bcd_down_counter_n against a decimal
// integer reference model of the countdown timer.
module tb_bcd_down_counter_n;

  localparam int DIGITS = 3;
  localparam int DIV    = 4;
  localparam int W      = 4 * DIGITS;

  logic          CLOCK_50 = 1'b0;
  logic          KEY      = 1'b1;
  logic          en       = 1'b0;
  logic          load     = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic          auto_reload = 1'b0;
  logic [W-1:0]  count;
  logic          tick, zero, done, running;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  // Reference model state: count as a plain decimal integer.
  int m_count = 0;
  int m_presc = 0;
  bit m_tick  = 1'b0;
  bit m_done  = 1'b0;
  bit m_run   = 1'b0;

  bcd_down_counter_n #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .CLOCK_50    (CLOCK_50),
    .KEY         (KEY),
    .en          (en),
    .load        (load),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .count       (count),
    .tick        (tick),
    .zero        (zero),
    .done        (done),
    .running     (running)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_dec(input logic [W-1:0] lv);
    int v, pw, d;
    v  = 0;
    pw = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v  = v + d * pw;
      pw = pw * 10;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int k;
    k = n;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_count = 0; m_presc = 0; m_tick = 1'b0; m_done = 1'b0; m_run = 1'b0;
  endtask

  task automatic model_edge();
    int v;
    bit t;
    v = clamp_dec(load_value);
    if (load) begin
      m_count = v; m_presc = 0; m_tick = 1'b0; m_done = 1'b0; m_run = (v != 0);
    end else if (m_run && en) begin
      t      = m_tick;
      m_done = 1'b0;
      if (m_presc == DIV - 1) begin
        m_presc = 0; m_tick = 1'b1;
      end else begin
        m_presc = m_presc + 1; m_tick = 1'b0;
      end
      if (t) begin
        if (m_count != 0) begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_done = 1'b1;
            if (!auto_reload) m_run = 1'b0;
          end
        end else begin
          m_count = v;
          if (v == 0) begin
            m_done = 1'b1;
            if (!auto_reload) m_run = 1'b0;
          end
        end
      end
    end else begin
      m_tick = 1'b0; m_done = 1'b0;
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(to_bcd(m_count)));
    check("tick", 32'(tick), 32'(m_tick));
    check("done", 32'(done), 32'(m_done));
    check("running", 32'(running), 32'(m_run));
    check("zero", 32'(zero), 32'(m_count == 0));
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_all();
    if (done) done_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic async_reset();
    #2 KEY = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    model_reset();
    #1 KEY = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int waited;
    #1 KEY = 1'b0;
    #2;
    check("reset_count", 32'(count), 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_running", 32'(running), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge CLOCK_50);
    KEY = 1'b1;
    model_reset();

    // Basic one-shot countdown from 12.
    en = 1'b1; auto_reload = 1'b0;
    done_seen = 0;
    do_load(12'h012);
    run(60);
    check("oneshot_dones", 32'(done_seen), 32'd1);
    check("oneshot_idle", 32'(running), 32'd0);
    check("oneshot_hold", 32'(count), 32'd0);

    // Borrow across all three digits.
    done_seen = 0;
    do_load(12'h100);
    run(5);
    check("borrow_099", 32'(count), 32'h099);
    run(400);
    check("borrow_000", 32'(count), 32'h000);
    check("borrow_dones", 32'(done_seen), 32'd1);

    // Auto-reload: one done every four ticks.
    auto_reload = 1'b1;
    done_seen = 0;
    do_load(12'h003);
    run(48);
    check("reload_dones", 32'(done_seen), 32'd3);
    auto_reload = 1'b0;
    run(20);

    // Clamp and all-zero load.
    do_load(12'h0A5);
    check("clamp_95", 32'(count), 32'h095);
    done_seen = 0;
    do_load(12'h000);
    run(8);
    check("zero_load_idle", 32'(running), 32'd0);
    check("zero_load_nodone", 32'(done_seen), 32'd0);

    // Pause mid-count, then resume.
    do_load(12'h050);
    run(6);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(20);

    // Load colliding with the decrement edge at count 01 must suppress done.
    do_load(12'h001);
    waited = 0;
    while (!tick && waited < 10) begin
      step();
      waited++;
    end
    check("collide_tick_seen", 32'(tick), 32'd1);
    done_seen = 0;
    do_load(12'h222);
    check("collide_value", 32'(count), 32'h222);
    check("collide_nodone", 32'(done_seen), 32'd0);
    run(5);

    // Asynchronous reset while showing 07.
    do_load(12'h008);
    run(5);
    check("pre_rst_07", 32'(count), 32'h007);
    async_reset();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom;
      if (r[5:0] == 6'd0) begin
        load = 1'b1;
        if (r[6]) begin
          load_value = to_bcd(int'($urandom_range(0, 15)));
        end else begin
          r = $urandom;
          load_value = r[W-1:0];
        end
      end else begin
        load = 1'b0;
      end
      r = $urandom;
      en = (r[3:0] != 4'd0);
      if (r[9:4] == 6'd0) auto_reload = ~auto_reload;
      step();
      load = 1'b0;
      r = $urandom;
      if (r[9:0] == 10'd0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
